// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
//   Round-robin AXI4 read master shared by NUM_CLIENTS requesters (I/D cache
//   line fills and uncached word reads). One transaction is in flight at a
//   time. Each request is either a BEATS x 32-bit INCR line burst or a
//   single 32-bit beat.
//
// Ports
//   aclk, aresetn         clock, synchronous active-low reset
//   cl_req/burst/addr     per-client request level, mode, 32-bit address
//   cl_ack                one-cycle pulse, request accepted
//   cl_rvalid             one-cycle pulse, cl_rdata/cl_rerr valid for that client
//   cl_rdata, cl_rerr     shared line buffer and sticky error flag
//   m_axi_ar*             AXI4 read address channel
//   m_axi_r*              AXI4 read data channel
module axi_rd_arbiter #(
  parameter int         NUM_CLIENTS  = 4,
  parameter int         BEATS        = 4,
  parameter logic [3:0] AXI_ID       = 4'h0,
  parameter logic [3:0] CACHE_BURST  = 4'b1111,
  parameter logic [3:0] CACHE_SINGLE = 4'b0010
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_CLIENTS-1:0]   cl_req,
  input  logic [NUM_CLIENTS-1:0]   cl_burst,
  input  logic [32*NUM_CLIENTS-1:0] cl_addr,
  output logic [NUM_CLIENTS-1:0]   cl_ack,
  output logic [NUM_CLIENTS-1:0]   cl_rvalid,
  output logic [32*BEATS-1:0]      cl_rdata,
  output logic                     cl_rerr,
  output logic [3:0]               m_axi_arid,
  output logic [31:0]              m_axi_araddr,
  output logic [7:0]               m_axi_arlen,
  output logic [2:0]               m_axi_arsize,
  output logic [1:0]               m_axi_arburst,
  output logic [3:0]               m_axi_arcache,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [3:0]               m_axi_rid,
  input  logic [31:0]              m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rlast,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready
);

  localparam int LINE_W = 32 * BEATS;
  localparam int GW     = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CW     = $clog2(BEATS);
  // Line bursts start on a line boundary: clear log2(BEATS*4) address bits.
  localparam logic [31:0] BURST_MASK = ~(32'(BEATS * 4) - 32'd1);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [GW-1:0]       r_rr_last;
  logic [GW-1:0]       r_gnt;
  logic                r_ack;
  logic [31:0]         r_araddr;
  logic [7:0]          r_arlen;
  logic [2:0]          r_arsize;
  logic [1:0]          r_arburst;
  logic [3:0]          r_arcache;
  logic [CW-1:0]       r_cnt;
  logic [LINE_W-1:0]   r_buf;
  logic                r_err;

  logic                w_found;
  logic [GW-1:0]       w_gnt;
  logic [GW-1:0]       w_idx;
  logic [31:0]         w_sel_addr;
  logic                w_beat;
  logic                w_cnt_last;
  logic                w_done;
  logic                w_unused_rresp0;

  // Round-robin search starting one past the last grant, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int i = 1; i <= NUM_CLIENTS; i++) begin
      w_idx = GW'((int'(r_rr_last) + i) % NUM_CLIENTS);
      if (!w_found && cl_req[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  assign w_sel_addr = cl_addr[32*w_gnt +: 32];

  // Beats with a foreign ID are still consumed (rready high) but ignored.
  assign w_beat     = (r_state == S_R) && m_axi_rvalid && (m_axi_rid == AXI_ID);
  assign w_cnt_last = (8'(r_cnt) == r_arlen);
  assign w_done     = w_beat && (m_axi_rlast || w_cnt_last);

  // Only SLVERR/DECERR (rresp[1]) flag an error; OKAY/EXOKAY do not.
  assign w_unused_rresp0 = m_axi_rresp[0];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    cl_ack        = '0;
    cl_rvalid     = '0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) w_next = S_AR;
      end
      S_AR: begin
        m_axi_arvalid = 1'b1;
        if (r_ack) cl_ack[r_gnt] = 1'b1;
        if (m_axi_arready) w_next = S_R;
      end
      S_R: begin
        m_axi_rready = 1'b1;
        if (w_done) w_next = S_RESP;
      end
      S_RESP: begin
        cl_rvalid[r_gnt] = 1'b1;
        w_next           = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rr_last <= GW'(NUM_CLIENTS - 1);
      r_gnt     <= '0;
      r_ack     <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_arcache <= '0;
      r_cnt     <= '0;
      r_buf     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (r_state == S_IDLE && w_found) begin
        r_rr_last <= w_gnt;
        r_gnt     <= w_gnt;
        r_ack     <= 1'b1;
        r_arsize  <= 3'd2;
        r_arburst <= 2'b01;
        r_cnt     <= '0;
        r_buf     <= '0;
        r_err     <= 1'b0;
        if (cl_burst[w_gnt]) begin
          r_araddr  <= w_sel_addr & BURST_MASK;
          r_arlen   <= 8'(BEATS - 1);
          r_arcache <= CACHE_BURST;
        end else begin
          r_araddr  <= {w_sel_addr[31:2], 2'b00};
          r_arlen   <= 8'd0;
          r_arcache <= CACHE_SINGLE;
        end
      end
      if (w_beat) begin
        r_buf[32*r_cnt +: 32] <= m_axi_rdata;
        r_cnt                 <= r_cnt + 1'b1;
        // rlast and the expected last beat must coincide; either one alone
        // ends the transaction but marks it as a protocol error.
        if (m_axi_rresp[1] || (m_axi_rlast != w_cnt_last)) r_err <= 1'b1;
      end
    end
  end

  assign m_axi_arid    = AXI_ID;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = r_arlen;
  assign m_axi_arsize  = r_arsize;
  assign m_axi_arburst = r_arburst;
  assign m_axi_arcache = r_arcache;
  assign cl_rdata      = r_buf;
  assign cl_rerr       = r_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed testbench for axi_rd_arbiter with a small reactive AXI read slave.
module tb_axi_rd_arbiter;
  localparam int NC     = 4;
  localparam int BEATS  = 4;
  localparam int LINE_W = 32 * BEATS;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [NC-1:0]     cl_req = '0;
  logic [NC-1:0]     cl_burst = '0;
  logic [32*NC-1:0]  cl_addr = '0;
  logic [NC-1:0]     cl_ack, cl_rvalid;
  logic [LINE_W-1:0] cl_rdata;
  logic              cl_rerr;
  logic [3:0]        m_axi_arid, m_axi_arcache;
  logic [31:0]       m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_arvalid, m_axi_arready, m_axi_rready;
  logic [3:0]        m_axi_rid;
  logic [31:0]       m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast, m_axi_rvalid;

  axi_rd_arbiter #(.NUM_CLIENTS(NC), .BEATS(BEATS)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cl_req(cl_req), .cl_burst(cl_burst), .cl_addr(cl_addr),
    .cl_ack(cl_ack), .cl_rvalid(cl_rvalid), .cl_rdata(cl_rdata), .cl_rerr(cl_rerr),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arcache(m_axi_arcache), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Slave configuration and captured AR fields
  int          s_ar_delay = 0, s_gap = 0, s_nbeats = 1, s_last_at = 0;
  bit          s_foreign = 0;
  bit          s_busy = 0;
  logic [31:0] s_data [16];
  logic [1:0]  s_resp [16];
  logic [31:0] cap_addr;
  logic [7:0]  cap_len;
  logic [3:0]  cap_cache;
  logic [2:0]  cap_size;
  logic [1:0]  cap_burst;
  bit          ar_ok;

  task automatic cfg(input int dly, input int gap, input bit frn, input int nb, input int last_at);
    s_ar_delay = dly; s_gap = gap; s_foreign = frn; s_nbeats = nb; s_last_at = last_at;
    for (int i = 0; i < 16; i++) begin s_data[i] = '0; s_resp[i] = 2'b00; end
  endtask

  // Reactive slave: drives just after the rising edge
  initial begin
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rid = 0;
    m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0;
    forever begin
      @(posedge aclk); #1;
      if (m_axi_arvalid) begin
        s_busy = 1;
        cap_addr = m_axi_araddr; cap_len = m_axi_arlen; cap_cache = m_axi_arcache;
        cap_size = m_axi_arsize; cap_burst = m_axi_arburst; ar_ok = 1;
        for (int d = 0; d < s_ar_delay; d++) begin
          @(posedge aclk); #1;
          if (!m_axi_arvalid || m_axi_araddr !== cap_addr || m_axi_arlen !== cap_len ||
              m_axi_arcache !== cap_cache) ar_ok = 0;
        end
        m_axi_arready = 1;
        @(posedge aclk); #1;
        m_axi_arready = 0;
        for (int b = 0; b < s_nbeats; b++) begin
          for (int g = 0; g < s_gap; g++) begin
            m_axi_rvalid = 0; m_axi_rlast = 0;
            @(posedge aclk); #1;
          end
          if (s_foreign) begin
            m_axi_rvalid = 1; m_axi_rid = 4'h5; m_axi_rdata = 32'hBAD0_0000 + b;
            m_axi_rresp = 2'b10; m_axi_rlast = 1;
            @(posedge aclk); #1;
          end
          m_axi_rvalid = 1; m_axi_rid = 4'h0; m_axi_rdata = s_data[b];
          m_axi_rresp = s_resp[b]; m_axi_rlast = (b == s_last_at);
          @(posedge aclk); #1;
        end
        m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rid = 0; m_axi_rresp = 0;
        s_busy = 0;
      end
    end
  end

  // Log of client handshakes for ordering checks
  logic [NC-1:0] ack_q[$];
  logic [NC-1:0] rv_q[$];
  always @(negedge aclk) begin
    if (cl_ack != 0) ack_q.push_back(cl_ack);
    if (cl_rvalid != 0) rv_q.push_back(cl_rvalid);
  end

  task automatic do_reset();
    @(posedge aclk); #1 aresetn = 0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
  endtask

  task automatic txn(input string tag, input int cl, input bit burst, input logic [31:0] addr,
                     input logic [31:0] e_addr, input logic [7:0] e_len, input logic [3:0] e_cache,
                     input logic [127:0] e_data, input bit e_err, input bit chk_lat,
                     input logic [NC-1:0] also_req);
    int t0, e_lat;
    bit got;
    e_lat = burst ? 2 + BEATS : 3;
    @(posedge aclk); #1;
    cl_burst[cl] = burst; cl_addr[32*cl +: 32] = addr;
    cl_req = cl_req | also_req;
    cl_req[cl] = 1'b1;
    t0 = cyc;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge aclk);
      if (cl_ack != 0) got = 1;
    end
    check({tag, "_ack_seen"}, 128'(got), 128'(1));
    if (got) begin
      check({tag, "_ack"}, 128'(cl_ack), 128'(1) << cl);
      check({tag, "_arvalid"}, 128'(m_axi_arvalid), 128'(1));
      if (chk_lat) check({tag, "_ack_lat"}, 128'(cyc - t0), 128'(1));
    end
    @(posedge aclk); #1;
    cl_req[cl] = 1'b0;
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge aclk);
      if (cl_rvalid != 0) got = 1;
    end
    check({tag, "_rvalid_seen"}, 128'(got), 128'(1));
    if (got) begin
      check({tag, "_rvalid"}, 128'(cl_rvalid), 128'(1) << cl);
      check({tag, "_rdata"}, cl_rdata, e_data);
      check({tag, "_rerr"}, 128'(cl_rerr), 128'(e_err));
      if (chk_lat) check({tag, "_rv_lat"}, 128'(cyc - t0), 128'(e_lat));
    end
    check({tag, "_araddr"}, 128'(cap_addr), 128'(e_addr));
    check({tag, "_arlen"}, 128'(cap_len), 128'(e_len));
    check({tag, "_arcache"}, 128'(cap_cache), 128'(e_cache));
    check({tag, "_arsize_burst"}, 128'({cap_size, cap_burst}), 128'({3'd2, 2'b01}));
    check({tag, "_ar_stable"}, 128'(ar_ok), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rv0;
    bit got;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_ack_rvalid", 128'({cl_ack, cl_rvalid}), 128'(0));
    check("rst_arvalid_rready", 128'({m_axi_arvalid, m_axi_rready}), 128'(0));
    check("rst_ar_fields", 128'({m_axi_araddr, m_axi_arlen, m_axi_arcache, m_axi_arsize, m_axi_arburst}), 128'(0));
    check("rst_rdata", cl_rdata, 128'(0));
    check("rst_rerr", 128'(cl_rerr), 128'(0));
    check("rst_arid", 128'(m_axi_arid), 128'(0));
    @(posedge aclk); #1 aresetn = 1;

    // 1: client 0 line burst, zero-wait slave
    cfg(0, 0, 0, 4, 3);
    s_data[0] = 32'hA0; s_data[1] = 32'hA1; s_data[2] = 32'hA2; s_data[3] = 32'hA3;
    txn("t1", 0, 1, 32'h1000_0014, 32'h1000_0010, 8'd3, 4'b1111,
        {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, 1, '0);

    // 2: client 2 single word, upper line bits cleared
    cfg(0, 0, 0, 1, 0);
    s_data[0] = 32'hDEAD_BEEF;
    txn("t2", 2, 0, 32'h1FD0_0003, 32'h1FD0_0000, 8'd0, 4'b0010,
        {96'h0, 32'hDEAD_BEEF}, 0, 1, '0);

    // 4: delayed arready, gapped beats with foreign IDs, EXOKAY not an error
    cfg(5, 1, 1, 4, 3);
    s_data[0] = 32'hC0; s_data[1] = 32'hC1; s_data[2] = 32'hC2; s_data[3] = 32'hC3;
    s_resp[2] = 2'b01;
    txn("t4", 3, 1, 32'h2000_0048, 32'h2000_0040, 8'd3, 4'b1111,
        {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 0, 0, '0);

    // 5: SLVERR on beat 1 together with early rlast
    cfg(0, 0, 0, 2, 1);
    s_data[0] = 32'hB0; s_data[1] = 32'hB1; s_resp[1] = 2'b10;
    txn("t5", 0, 1, 32'h0000_1234, 32'h0000_1230, 8'd3, 4'b1111,
        {64'h0, 32'hB1, 32'hB0}, 1, 0, '0);

    // 7: burst that never signals rlast ends on the counter with an error
    cfg(0, 0, 0, 4, 99);
    s_data[0] = 32'hD0; s_data[1] = 32'hD1; s_data[2] = 32'hD2; s_data[3] = 32'hD3;
    txn("t7", 1, 1, 32'h3000_001C, 32'h3000_0010, 8'd3, 4'b1111,
        {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 1, 0, '0);

    // 3: all clients held high for 8 transactions
    do_reset();
    ack_q.delete(); rv_q.delete();
    cfg(0, 0, 0, 1, 0);
    s_data[0] = 32'h55;
    @(posedge aclk); #1;
    cl_burst = '0;
    cl_addr = {32'h40, 32'h30, 32'h20, 32'h10};
    cl_req = '1;
    n = 0;
    for (int k = 0; k < 400 && n < 8; k++) begin
      @(negedge aclk);
      if (cl_ack != 0) n++;
    end
    @(posedge aclk); #1 cl_req = '0;
    repeat (12) @(posedge aclk);
    check("t3_ack_count", 128'(n), 128'(8));
    check("t3_ackq_size", 128'(ack_q.size()), 128'(8));
    check("t3_rvq_size", 128'(rv_q.size()), 128'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < ack_q.size()) check($sformatf("t3_ack_%0d", i), 128'(ack_q[i]), 128'(1) << (i % 4));
      if (i < rv_q.size()) check($sformatf("t3_rv_%0d", i), 128'(rv_q[i]), 128'(1) << (i % 4));
    end

    // 6: reset while in R after two beats
    cfg(0, 0, 0, 4, 3);
    s_data[0] = 32'hE0; s_data[1] = 32'hE1; s_data[2] = 32'hE2; s_data[3] = 32'hE3;
    @(posedge aclk); #1;
    cl_burst[1] = 1; cl_addr[63:32] = 32'h5000_0000; cl_req[1] = 1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge aclk);
      if (cl_ack != 0) got = 1;
    end
    check("t6_ack_seen", 128'(got), 128'(1));
    @(posedge aclk); #1 cl_req[1] = 0;
    n = 0;
    for (int k = 0; k < 50 && n < 2; k++) begin
      @(negedge aclk);
      if (m_axi_rvalid && m_axi_rready && m_axi_rid == 4'h0) n++;
    end
    check("t6_two_beats", 128'(n), 128'(2));
    @(posedge aclk); #1 aresetn = 0;
    rv0 = rv_q.size();
    @(posedge aclk);
    @(negedge aclk);
    check("t6_rst_ctl", 128'({cl_ack, cl_rvalid, m_axi_rready, m_axi_arvalid, cl_rerr}), 128'(0));
    check("t6_rst_araddr", 128'(m_axi_araddr), 128'(0));
    check("t6_rst_arlen_cache", 128'({m_axi_arlen, m_axi_arcache}), 128'(0));
    check("t6_rst_rdata", cl_rdata, 128'(0));
    @(posedge aclk); #1 aresetn = 1;
    for (int k = 0; k < 50 && s_busy; k++) @(posedge aclk);
    check("t6_slave_idle", 128'(s_busy), 128'(0));
    repeat (3) @(posedge aclk);
    check("t6_no_rvalid", 128'(rv_q.size()), 128'(rv0));

    // After reset priority restarts at client 0: clients 1 and 3 -> 1 first
    cfg(0, 0, 0, 4, 3);
    s_data[0] = 32'hF0; s_data[1] = 32'hF1; s_data[2] = 32'hF2; s_data[3] = 32'hF3;
    cl_burst[3] = 1; cl_addr[127:96] = 32'h6000_0024;
    txn("t6b", 1, 1, 32'h5000_0008, 32'h5000_0000, 8'd3, 4'b1111,
        {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 0, 0, 4'b1000);
    txn("t6c", 3, 1, 32'h6000_0024, 32'h6000_0020, 8'd3, 4'b1111,
        {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 0, 0, '0);

    repeat (4) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Parametrised AXI4 read-side master that arbitrates NUM_CLIENTS read clients onto one AR/R channel pair. Clients are I/D cache line fills and uncached word reads.
- Each request is either a line burst (BEATS x 32-bit, INCR) or a single 32-bit uncached beat, selected per request.
- Round-robin arbitration, one outstanding transaction, per-transaction error reporting.
- Sits between the cache/uncache units and the SoC AXI interconnect. The write path is separate.

Parameters:
- NUM_CLIENTS, 4: number of requesters, 2..8.
- BEATS, 4: beats per line burst; power of two, 2..16. LINE_W = 32*BEATS.
- AXI_ID, 4'h0: constant value driven on m_axi_arid; accepted value on m_axi_rid.
- CACHE_BURST, 4'b1111: m_axi_arcache value for burst requests.
- CACHE_SINGLE, 4'b0010: m_axi_arcache value for single-beat requests.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  reset; synchronous, active-low.
- cl_req  in  NUM_CLIENTS  per-client read request level; held until that client's cl_ack.
- cl_burst  in  NUM_CLIENTS  1 = line burst, 0 = single word.
- cl_addr  in  32*NUM_CLIENTS  client i address in bits [32i+31:32i].
- cl_ack  out  NUM_CLIENTS  one-cycle pulse: request accepted.
- cl_rvalid  out  NUM_CLIENTS  one-cycle pulse: data ready for that client.
- cl_rdata  out  LINE_W  shared read data; valid while any cl_rvalid is high.
- cl_rerr  out  1  SLVERR/DECERR or protocol error seen in this transaction; qualified by cl_rvalid.
- m_axi_arid  out  4  AXI_ID.
- m_axi_araddr  out  32  read address.
- m_axi_arlen  out  8  burst length minus one.
- m_axi_arsize  out  3  always 3'd2.
- m_axi_arburst  out  2  always 2'b01 (INCR).
- m_axi_arcache  out  4  CACHE_BURST or CACHE_SINGLE.
- m_axi_arvalid  out  1  AR valid.
- m_axi_arready  in  1  AR ready.
- m_axi_rid  in  4  read ID.
- m_axi_rdata  in  32  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rlast  in  1  last beat.
- m_axi_rvalid  in  1  R valid.
- m_axi_rready  out  1  R ready.

Behaviour:
- Reset (aresetn low at an edge): state = IDLE; all outputs 0 except m_axi_arid; rr_last = NUM_CLIENTS-1; beat counter 0; buffer 0; error flag 0.
- Reset mid-transaction abandons the transaction; nothing is pulsed to any client afterwards.
- FSM states are IDLE -> AR -> R -> RESP -> IDLE.
- IDLE:
  - If any cl_req is high, grant the first requester searching from rr_last+1 with wrap.
  - At that edge: rr_last = grant; latch addr/burst; clear buffer, counter and error flag.
  - Next cycle: cl_ack[grant] = 1 for exactly one cycle and m_axi_arvalid = 1; go to AR.
- Request with no ack: a client dropping cl_req before its ack is ignored.
- AR channel fields:
  - araddr: burst = addr with the low log2(BEATS*4) bits cleared; single = addr with bits [1:0] cleared.
  - arlen: BEATS-1 for burst, 0 for single.
  - arcache: per mode.
  - All AR fields stay stable while arvalid is high.
- AR: hold until m_axi_arready; on the handshake, arvalid drops at the next edge and the state goes to R.
- R: m_axi_rready = 1 only in this state. A beat is accepted when rvalid and rid == AXI_ID; mismatched-ID beats are consumed and dropped.
- Each accepted beat:
  - Write it to buffer[32*cnt +: 32] and increment cnt.
  - Set the error flag if rresp[1] = 1.
- Transaction end: the beat with rlast = 1, or the beat with cnt == arlen, whichever comes first; go to RESP.
- Protocol errors set the error flag:
  - rlast arriving before cnt == arlen;
  - cnt == arlen reached without rlast.
- Single-word transactions: data sits in cl_rdata[31:0]; upper bits are 0.
- RESP: cl_rvalid[grant] = 1 for one cycle with cl_rdata = buffer and cl_rerr = flag; return to IDLE.
- A new grant can be made in the IDLE cycle right after RESP.
- Latency with zero-wait slave and arready high in the first AR cycle:
  - req at cycle T; ack and arvalid at T+1;
  - beats T+2 .. T+1+beats;
  - cl_rvalid the cycle after the last beat.
- Simultaneous requests are served strictly round-robin. A client holding cl_req continuously waits at most NUM_CLIENTS-1 transactions.
- cl_ack, cl_rvalid and m_axi_rready are never high outside the states listed above.

Test Plan:
1. Reset then client 0 burst at 0x1000_0014, BEATS=4, beats 0xA0..0xA3 with rlast on beat 3 -> araddr 0x1000_0010, arlen 3, arcache 4'b1111; cl_rvalid[0] with cl_rdata = {A3,A2,A1,A0}, cl_rerr = 0.
2. Client 2 single read at 0x1FD0_0003, rdata 0xDEADBEEF -> araddr 0x1FD0_0000, arlen 0, arcache 4'b0010; cl_rdata = 0x...0000_DEADBEEF (upper 0).
3. All four cl_req held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3; each client gets exactly one ack and one rvalid per grant.
4. arready delayed 5 cycles, rvalid gapped with interleaved rid = 4'h5 beats -> AR fields stable throughout; foreign beats dropped; data correct.
5. Burst where beat 1 has rresp = 2'b10, then rlast on beat 1 -> cl_rvalid after beat 1 with cl_rerr = 1.
6. aresetn low in state R after 2 beats -> next cycle all outputs 0; no cl_rvalid; a new request after reset starts with client 0 priority.
